// File: rtl/read_issue_scoreboard_if.sv
// read_issue_scoreboard_if: decode-to-issue handshake, writeback, flush and scoreboard status bundle
// Signals: in_valid/in_ready handshake with in_ra/in_rb/in_rd ids and their *_used flags,
//   issue_valid to the Read stage, wb_valid/wb_rd writeback retire, flush, and status outputs
//   busy_mask, stalled, stall_count. master = upstream/driver side, slave = scoreboard side.
interface read_issue_scoreboard_if #(
    parameter int REG_COUNT = 32,
    parameter int REG_ID_WIDTH = $clog2(REG_COUNT),
    parameter int STALL_CNT_WIDTH = 16
);
    logic in_valid;
    logic in_ready;
    logic [REG_ID_WIDTH-1:0] in_ra;
    logic [REG_ID_WIDTH-1:0] in_rb;
    logic [REG_ID_WIDTH-1:0] in_rd;
    logic in_ra_used;
    logic in_rb_used;
    logic in_rd_used;
    logic issue_valid;
    logic wb_valid;
    logic [REG_ID_WIDTH-1:0] wb_rd;
    logic flush;
    logic [REG_COUNT-1:0] busy_mask;
    logic stalled;
    logic [STALL_CNT_WIDTH-1:0] stall_count;
    modport master (
        output in_valid, in_ra, in_rb, in_rd, in_ra_used, in_rb_used, in_rd_used, wb_valid, wb_rd, flush,
        input in_ready, issue_valid, busy_mask, stalled, stall_count
    );
    modport slave (
        input in_valid, in_ra, in_rb, in_rd, in_ra_used, in_rb_used, in_rd_used, wb_valid, wb_rd, flush,
        output in_ready, issue_valid, busy_mask, stalled, stall_count
    );
endinterface

// File: rtl/read_issue_scoreboard.sv
// read_issue_scoreboard: register scoreboard and issue controller in front of the Read stage
// Ports: clk; rst (synchronous, active-high); sb (read_issue_scoreboard_if.slave):
//   in_* decoded instruction + in_ready, issue_valid (registered Read insn.valid),
//   wb_valid/wb_rd writeback clear, flush, busy_mask, stalled, stall_count (saturating).
// Build option: SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback unblock a dependent
//   instruction; undefined, the dependent issues the cycle after the writeback.
module read_issue_scoreboard #(
    parameter int REG_COUNT = 32,
    parameter int REG_ID_WIDTH = $clog2(REG_COUNT),
    parameter int STALL_CNT_WIDTH = 16
) (
    input logic clk,
    input logic rst,
    read_issue_scoreboard_if.slave sb
);
    typedef enum logic {RUN, STALL} state_t;
    state_t state, state_next;
    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_chk;
    logic [REG_COUNT-1:0] wb_clr;
    logic [REG_COUNT-1:0] rd_set;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic issue_q;
    logic hazard;
    logic issue;
    // busy[0] is never set, so a writeback or read of r0 needs no special casing
    assign wb_clr = sb.wb_valid ? REG_COUNT'(1) << sb.wb_rd : '0;
    assign rd_set = (issue && sb.in_rd_used && sb.in_rd != '0) ? REG_COUNT'(1) << sb.in_rd : '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    assign busy_chk = busy & ~wb_clr;
`else
    assign busy_chk = busy;
`endif
    assign hazard = (sb.in_ra_used & busy_chk[sb.in_ra])
                  | (sb.in_rb_used & busy_chk[sb.in_rb])
                  | (sb.in_rd_used & busy_chk[sb.in_rd]);
    assign sb.in_ready = ~rst & ~sb.flush & ~hazard;
    assign issue = sb.in_valid & sb.in_ready;
    always_comb begin
        state_next = state;
        if (state == RUN)
            state_next = (sb.in_valid && !sb.in_ready && !sb.flush) ? STALL : RUN;
        else
            state_next = (issue || !sb.in_valid || sb.flush) ? RUN : STALL;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            busy <= '0;
            issue_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            // the newer writer's set is ORed after the clear so it wins on a collision
            busy <= sb.flush ? '0 : (busy & ~wb_clr) | rd_set;
            issue_q <= issue;
            stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(state == STALL && !(&stall_cnt));
        end
    end
    assign sb.issue_valid = issue_q;
    assign sb.busy_mask = busy;
    assign sb.stalled = state == STALL;
    assign sb.stall_count = stall_cnt;
endmodule

// File: tb/tb_read_issue_scoreboard.sv
// tb_read_issue_scoreboard: self-checking bench with an issue-cycle scoreboard queue
module tb_read_issue_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_stall = 0;
    int exp_q[$];
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAST = BYP ? 5 : 6;

    read_issue_scoreboard_if #(.STALL_CNT_WIDTH(16)) sb16();
    read_issue_scoreboard_if #(.STALL_CNT_WIDTH(4)) sb4();
    read_issue_scoreboard #(.STALL_CNT_WIDTH(16)) dut16 (.clk(clk), .rst(rst), .sb(sb16));
    read_issue_scoreboard #(.STALL_CNT_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .sb(sb4));

    assign sb4.in_valid = sb16.in_valid;
    assign sb4.in_ra = sb16.in_ra;
    assign sb4.in_rb = sb16.in_rb;
    assign sb4.in_rd = sb16.in_rd;
    assign sb4.in_ra_used = sb16.in_ra_used;
    assign sb4.in_rb_used = sb16.in_rb_used;
    assign sb4.in_rd_used = sb16.in_rd_used;
    assign sb4.wb_valid = sb16.wb_valid;
    assign sb4.wb_rd = sb16.wb_rd;
    assign sb4.flush = sb16.flush;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // issue_valid must be high exactly in the cycles the scoreboard queue predicts
    always @(negedge clk) begin
        logic exp_iv;
        if (!rst) begin
            exp_iv = exp_q.size() != 0 && exp_q[0] == cyc;
            if (exp_iv) void'(exp_q.pop_front());
            check("issue_valid", 32'(sb16.issue_valid), 32'(exp_iv));
        end
    end

    task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                         input logic [2:0] u, input logic wv, input logic [4:0] wr, input logic fl,
                         input logic rdy, input string tag);
        sb16.in_valid = v;
        sb16.in_ra = ra;
        sb16.in_rb = rb;
        sb16.in_rd = rd;
        {sb16.in_ra_used, sb16.in_rb_used, sb16.in_rd_used} = u;
        sb16.wb_valid = wv;
        sb16.wb_rd = wr;
        sb16.flush = fl;
        #1;
        check(tag, 32'(sb16.in_ready), 32'(rdy));
        if (v && rdy) exp_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy16"}, sb16.busy_mask, 0);
        check({tag, "_iv16"}, 32'(sb16.issue_valid), 0);
        check({tag, "_cnt16"}, 32'(sb16.stall_count), 0);
        check({tag, "_stalled16"}, 32'(sb16.stalled), 0);
        check({tag, "_busy4"}, sb4.busy_mask, 0);
        check({tag, "_iv4"}, 32'(sb4.issue_valid), 0);
        check({tag, "_cnt4"}, 32'(sb4.stall_count), 0);
        check({tag, "_stalled4"}, 32'(sb4.stalled), 0);
    endtask

    initial begin
        drive(1, 0, 0, 3, 3'b001, 0, 0, 0, 0, "rst_in_ready");
        drive(1, 0, 0, 3, 3'b001, 0, 0, 0, 0, "rst_in_ready");
        check_reset("reset");
        rst = 1'b0;
        // independent stream
        for (int i = 1; i <= 3; i++)
            drive(1, 5'(10 + i), 5'(20 + i), 5'(i), 3'b111, 0, 0, 0, 1, "ind_ready");
        check("ind_busy", sb16.busy_mask, 32'h0000_000E);
        check("ind_cnt", 32'(sb16.stall_count), 0);
        check("ind_stalled", 32'(sb16.stalled), 0);
        drive(0, 0, 0, 0, 3'b000, 0, 0, 1, 0, "flush_ready");
        check("flush_busy", sb16.busy_mask, 0);
        // RAW on r5, writeback lands in the fifth cycle of the dependent's wait
        drive(1, 0, 0, 5, 3'b001, 0, 0, 0, 1, "raw_prod");
        check("raw_busy5", sb16.busy_mask, 32'h0000_0020);
        for (int i = 1; i <= LAST; i++) begin
            check("raw_stalled", 32'(sb16.stalled), 32'(i >= 2));
            drive(1, 5, 0, 0, 3'b100, i == 5, 5, 0, i == LAST, "raw_ready");
        end
        exp_stall = LAST - 1;
        check("raw_stalled_end", 32'(sb16.stalled), 0);
        check("raw_cnt", 32'(sb16.stall_count), 32'(exp_stall));
        check("raw_busy", sb16.busy_mask, 0);
        // same-cycle set and clear of r7: set wins
        if (BYP) drive(1, 0, 0, 7, 3'b001, 0, 0, 0, 1, "waw_prod");
        drive(1, 0, 0, 7, 3'b001, 1, 7, 0, 1, "waw_ready");
        check("waw_busy", sb16.busy_mask, 32'h0000_0080);
        drive(0, 0, 0, 0, 3'b000, 1, 7, 0, 1, "wb7_ready");
        check("wb7_busy", sb16.busy_mask, 0);
        // flush while stalled on r6 with r5/r6 busy
        drive(1, 0, 0, 5, 3'b001, 0, 0, 0, 1, "fl_prod5");
        drive(1, 0, 0, 6, 3'b001, 0, 0, 0, 1, "fl_prod6");
        drive(1, 6, 0, 0, 3'b100, 0, 0, 0, 0, "fl_hazard");
        check("fl_busy_pre", sb16.busy_mask, 32'h0000_0060);
        check("fl_stalled_pre", 32'(sb16.stalled), 1);
        drive(1, 6, 0, 0, 3'b100, 1, 5, 1, 0, "fl_flush_ready");
        exp_stall += 1;
        check("fl_busy", sb16.busy_mask, 0);
        check("fl_stalled", 32'(sb16.stalled), 0);
        check("fl_cnt", 32'(sb16.stall_count), 32'(exp_stall));
        drive(1, 6, 0, 0, 3'b100, 0, 0, 0, 1, "fl_reissue");
        // r0 reads and writes never hazard
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 3'b111, i[0], 0, 0, 1, "zero_ready");
        check("zero_busy", sb16.busy_mask, 0);
        check("zero_stalled", 32'(sb16.stalled), 0);
        // 20 stall cycles: 4-bit counter saturates, 16-bit keeps counting
        drive(1, 0, 0, 9, 3'b001, 0, 0, 0, 1, "sat_prod");
        for (int i = 0; i < 21; i++) drive(1, 9, 0, 0, 3'b100, 0, 0, 0, 0, "sat_ready");
        exp_stall += 20;
        check("sat_cnt4", 32'(sb4.stall_count), 15);
        check("sat_cnt16", 32'(sb16.stall_count), 32'(exp_stall));
        check("sat_stalled", 32'(sb16.stalled), 1);
        // reset mid-stall, then the still-presented instruction issues
        rst = 1'b1;
        drive(1, 9, 0, 0, 3'b100, 0, 0, 0, 0, "rst2_in_ready");
        check_reset("reset2");
        rst = 1'b0;
        drive(1, 9, 0, 0, 3'b100, 0, 0, 0, 1, "post_rst_ready");
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 1, "idle_ready");
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
